// File: rtl/systolic_operand_loader.sv
// Byte-serial loader: assembles one A and one B BF16 vector per 16-byte frame into a shadow buffer,
// then hands it to a double-buffered output register. Optional macro: SYSTOLIC_LOADER_BF16_FTZ_EN.
module systolic_operand_loader #(
  parameter int NELEM = 4,
  parameter int EW    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  frame_clr,
  input  logic [7:0]            in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NELEM*EW-1:0]   a_vec,
  output logic [NELEM*EW-1:0]   b_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            byte_idx
);

  localparam int BPE = EW / 8;
  localparam int FB  = 2 * NELEM * BPE;

  logic [7:0]          shadow_reg [FB];
  logic [3:0]          byte_idx_reg;
  logic                shadow_full_reg;
  logic                out_valid_reg;
  logic [NELEM*EW-1:0] a_vec_reg, b_vec_reg;
  logic [NELEM*EW-1:0] a_next, b_next;
  logic                xfer, accept, last_byte;

  assign xfer      = ena & shadow_full_reg & (~out_valid_reg | out_ready);
  assign in_ready  = ena & (~shadow_full_reg | xfer);
  assign accept    = in_valid & in_ready & ~frame_clr;
  assign last_byte = (byte_idx_reg == 4'(FB - 1));

  // Shadow bytes are MSB-first per element: A elements first, then B.
  for (genvar gi = 0; gi < NELEM; gi++) begin : g_elem
    logic [EW-1:0] a_elem, b_elem;
    for (genvar gj = 0; gj < BPE; gj++) begin : g_byte
      assign a_elem[EW-8*(gj+1) +: 8] = shadow_reg[gi*BPE + gj];
      assign b_elem[EW-8*(gj+1) +: 8] = shadow_reg[NELEM*BPE + gi*BPE + gj];
    end
`ifdef SYSTOLIC_LOADER_BF16_FTZ_EN
    // Zero exponent means denormal (or zero): keep sign, clear the rest.
    assign a_next[EW*gi +: EW] = (a_elem[EW-2:EW-9] == 8'd0) ? {a_elem[EW-1], {(EW-1){1'b0}}} : a_elem;
    assign b_next[EW*gi +: EW] = (b_elem[EW-2:EW-9] == 8'd0) ? {b_elem[EW-1], {(EW-1){1'b0}}} : b_elem;
`else
    assign a_next[EW*gi +: EW] = a_elem;
    assign b_next[EW*gi +: EW] = b_elem;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FB; i++) shadow_reg[i] <= 8'd0;
      byte_idx_reg    <= 4'd0;
      shadow_full_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      a_vec_reg       <= '0;
      b_vec_reg       <= '0;
    end else if (ena) begin
      if (frame_clr) begin
        // Abort wins over accept and transfer; the consumer handshake still completes.
        byte_idx_reg    <= 4'd0;
        shadow_full_reg <= 1'b0;
        if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
      end else begin
        if (accept) begin
          shadow_reg[byte_idx_reg] <= in_byte;
          byte_idx_reg             <= last_byte ? 4'd0 : byte_idx_reg + 4'd1;
        end
        if (accept && last_byte) shadow_full_reg <= 1'b1;
        else if (xfer)           shadow_full_reg <= 1'b0;
        if (xfer) begin
          a_vec_reg     <= a_next;
          b_vec_reg     <= b_next;
          out_valid_reg <= 1'b1;
        end else if (out_valid_reg && out_ready) begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign a_vec     = a_vec_reg;
  assign b_vec     = b_vec_reg;
  assign out_valid = out_valid_reg;
  assign byte_idx  = byte_idx_reg;

endmodule

// File: tb/tb_systolic_operand_loader.sv
// Directed bench for systolic_operand_loader: streaming, backpressure, abort, reset and FTZ frames.
module tb_systolic_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n, ena, frame_clr, in_valid, out_ready;
  logic [7:0]  in_byte;
  logic        in_ready, out_valid;
  logic [63:0] a_vec, b_vec;
  logic [3:0]  byte_idx;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] F1 = 128'h3F80_4000_4040_4080_3F80_3F80_3F80_3F80;
  localparam logic [127:0] F2 = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
  localparam logic [127:0] F3 = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
  localparam logic [127:0] F4 = 128'h0005_3F80_3F80_3F80_3F80_807F_3F80_3F80;

  systolic_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .frame_clr(frame_clr),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid),
    .out_ready(out_ready), .byte_idx(byte_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [127:0] f);
    for (int k = 0; k < 16; k++) begin
      in_byte  = f[127-8*k -: 8];
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  logic [255:0] two;

  initial begin
    rst_n = 1'b0; ena = 1'b1; frame_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_byte = 8'h00;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst byte_idx", 64'(byte_idx), 64'd0);
    check("rst a_vec", a_vec, 64'd0);
    check("rst b_vec", b_vec, 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();

    // Two back-to-back frames with continuous in_valid and out_ready.
    two = {F1, F2};
    for (int k = 0; k < 32; k++) begin
      in_byte  = two[255-8*k -: 8];
      in_valid = 1'b1;
      check($sformatf("stream in_ready[%0d]", k), 64'(in_ready), 64'd1);
      step();
      check($sformatf("stream out_valid[%0d]", k), 64'(out_valid), 64'(k == 16));
      if (k == 16) begin
        check("frame1 a_vec", a_vec, 64'h4080_4040_4000_3F80);
        check("frame1 b_vec", b_vec, 64'h3F80_3F80_3F80_3F80);
      end
    end
    in_valid = 1'b0;
    step();
    check("frame2 out_valid", 64'(out_valid), 64'd1);
    check("frame2 a_vec", a_vec, 64'h0708_0506_0304_0102);
    check("frame2 b_vec", b_vec, 64'h0F10_0D0E_0B0C_090A);

    // Backpressure: output held, shadow fills, extra byte must be ignored.
    out_ready = 1'b0;
    send_frame(F3);
    check("bp in_ready", 64'(in_ready), 64'd0);
    check("bp byte_idx", 64'(byte_idx), 64'd0);
    in_byte = 8'hEE; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("bp held in_ready", 64'(in_ready), 64'd0);
    check("bp held a_vec", a_vec, 64'h0708_0506_0304_0102);
    check("bp held byte_idx", 64'(byte_idx), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 64'(in_ready), 64'd1);
    step();
    check("frame3 out_valid", 64'(out_valid), 64'd1);
    check("frame3 a_vec", a_vec, 64'hA6A7_A4A5_A2A3_A0A1);
    check("frame3 b_vec", b_vec, 64'hAEAF_ACAD_AAAB_A8A9);
    check("frame3 byte_idx", 64'(byte_idx), 64'd0);
    step();
    check("frame3 taken", 64'(out_valid), 64'd0);

    // Abort a partial frame, then send a full one.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_byte = 8'hFF; in_valid = 1'b1; step();
    end
    check("partial byte_idx", 64'(byte_idx), 64'd5);
    frame_clr = 1'b1; in_byte = 8'h55;
    step();
    frame_clr = 1'b0; in_valid = 1'b0;
    check("clr byte_idx", 64'(byte_idx), 64'd0);
    send_frame(F1);
    step();
    check("clr frame out_valid", 64'(out_valid), 64'd1);
    check("clr frame a_vec", a_vec, 64'h4080_4040_4000_3F80);
    check("clr frame b_vec", b_vec, 64'h3F80_3F80_3F80_3F80);
    check("clr frame byte_idx", 64'(byte_idx), 64'd0);

    // Asynchronous reset in the middle of a frame.
    for (int k = 0; k < 9; k++) begin
      in_byte = F2[127-8*k -: 8]; in_valid = 1'b1; step();
    end
    in_valid = 1'b0;
    check("mid byte_idx", 64'(byte_idx), 64'd9);
    #3 rst_n = 1'b0;
    #1;
    check("async out_valid", 64'(out_valid), 64'd0);
    check("async byte_idx", 64'(byte_idx), 64'd0);
    check("async a_vec", a_vec, 64'd0);
    #2 rst_n = 1'b1;
    step();

    // Disabled block: nothing accepted.
    ena = 1'b0; in_byte = 8'h77; in_valid = 1'b1;
    #1;
    check("ena0 in_ready", 64'(in_ready), 64'd0);
    step();
    check("ena0 byte_idx", 64'(byte_idx), 64'd0);
    ena = 1'b1; in_valid = 1'b0;

    out_ready = 1'b1;
    send_frame(F2);
    step();
    check("post-rst a_vec", a_vec, 64'h0708_0506_0304_0102);
    check("post-rst b_vec", b_vec, 64'h0F10_0D0E_0B0C_090A);

    // Denormal elements: flushed only when the FTZ build option is on.
    send_frame(F4);
    step();
`ifdef SYSTOLIC_LOADER_BF16_FTZ_EN
    check("ftz a0", 64'(a_vec[15:0]), 64'h0000);
    check("ftz b1", 64'(b_vec[31:16]), 64'h8000);
`else
    check("ftz a0", 64'(a_vec[15:0]), 64'h0005);
    check("ftz b1", 64'(b_vec[31:16]), 64'h807F);
`endif
    check("ftz a3", 64'(a_vec[63:48]), 64'h3F80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
